// File: rtl/watch_core.sv
// watch_core: HH:MM:SS timekeeping core with prescaler, switch-driven time
// setting, 12/24-hour display, minute-resolution alarm and registered
// active-low seven-segment outputs.
//
// Parameters
//   CLK_HZ      mclk cycles per second (prescaler counts 0..CLK_HZ-1)
//   ALARM_SECS  seconds the alarm stays asserted once triggered
//   SYNC_STAGES synchroniser depth on each used options bit
// Ports
//   mclk          system clock
//   rst_n         asynchronous active-low reset
//   options[9:0]  slide switches: [0] run, [1] 12h, [3:2] set field
//                 (00 none, 01 sec, 10 min, 11 hr), [4] increment,
//                 [5] alarm edit, [6] alarm enable, [9:7] ignored
//   seg0..seg5    active-low segments (bit0=a .. bit6=g), seg0 = sec units
//   pm            displayed hour >= 12
//   alarm         alarm active

// One seven-segment digit encoder (active-low, gfedcba). Non-decimal codes
// and the blank request both produce an all-off digit.
module seg_digit (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        if (!blank) begin
            unique case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'h7F;
            endcase
        end
    end
endmodule

module watch_core #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int ALARM_SECS  = 30,
    parameter int SYNC_STAGES = 2
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [9:0] options,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [6:0] seg5,
    output logic       pm,
    output logic       alarm
);
    localparam int NUM_DIGITS = 6;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef struct packed {
        logic       aen;
        logic       aedit;
        logic       inc;
        logic [1:0] field;
        logic       h12;
        logic       run;
    } opts_t;

    // Reserved switches have no function.
    logic unused_rsvd;
    assign unused_rsvd = ^options[9:7];

    // ---------------- switch synchroniser ----------------
    logic [SYNC_STAGES-1:0][6:0] sync_q;
    opts_t s;
    assign s = opts_t'(sync_q[SYNC_STAGES-1]);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= options[6:0];
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic inc_q;
    logic inc_edge;
    assign inc_edge = s.inc & ~inc_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) inc_q <= 1'b0;
        else        inc_q <= s.inc;
    end

    // ---------------- prescaler ----------------
    logic [PW-1:0] presc;
    logic          counting;
    logic          tick;
    assign counting = s.run && (s.field == 2'b00);
    assign tick     = counting && (presc == PRESC_MAX);

    // Held at 0 whenever not counting, so every setting period (including
    // seconds edits) restarts the second from scratch.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)        presc <= '0;
        else if (!counting) presc <= '0;
        else if (tick)      presc <= '0;
        else                presc <= presc + PW'(1);
    end

    // ---------------- time and alarm registers ----------------
    logic [5:0] tm_sec, tm_min, al_min;
    logic [4:0] tm_hr, al_hr;
    logic [5:0] nx_sec, nx_min;
    logic [4:0] nx_hr;
    logic       sec_wrap, min_wrap;

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    // Full carry chain for a tick; 23:59:59 rolls to 00:00:00 in one step.
    always_comb begin
        sec_wrap = (tm_sec == 6'd59);
        min_wrap = (tm_min == 6'd59);
        nx_sec   = inc60(tm_sec);
        nx_min   = sec_wrap ? inc60(tm_min) : tm_min;
        nx_hr    = (sec_wrap && min_wrap) ? inc24(tm_hr) : tm_hr;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            tm_sec <= '0;
            tm_min <= '0;
            tm_hr  <= '0;
        end else if (tick) begin
            tm_sec <= nx_sec;
            tm_min <= nx_min;
            tm_hr  <= nx_hr;
        end else if (inc_edge && !s.aedit) begin
            case (s.field)
                2'b01:   tm_sec <= inc60(tm_sec);
                2'b10:   tm_min <= inc60(tm_min);
                2'b11:   tm_hr  <= inc24(tm_hr);
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            al_min <= '0;
            al_hr  <= '0;
        end else if (inc_edge && s.aedit) begin
            case (s.field)
                2'b10:   al_min <= inc60(al_min);
                2'b11:   al_hr  <= inc24(al_hr);
                default: ;
            endcase
        end
    end

    // ---------------- alarm ----------------
    logic [AW-1:0] acnt, acnt_d;
    logic          trig;

    // Fires only on the tick that lands on second 0 of the alarm minute.
    assign trig = s.aen && tick && sec_wrap && (nx_min == al_min) && (nx_hr == al_hr);

    always_comb begin
        acnt_d = acnt;
        if (!s.aen)                    acnt_d = '0;
        else if (trig)                 acnt_d = AW'(ALARM_SECS);
        else if (tick && acnt != '0)   acnt_d = acnt - AW'(1);
    end

    // alarm tracks the counter's next value so it changes on the same edge
    // as the counter rather than one cycle behind it.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            acnt  <= '0;
            alarm <= 1'b0;
        end else begin
            acnt  <= acnt_d;
            alarm <= (acnt_d != '0);
        end
    end

    // ---------------- display ----------------
    logic [4:0] src_hr, disp_hr;
    logic [5:0] src_min;
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0][6:0] seg_d, seg_q;

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    always_comb begin
        src_hr  = s.aedit ? al_hr  : tm_hr;
        src_min = s.aedit ? al_min : tm_min;
        disp_hr = src_hr;
        if (s.h12) begin
            if (src_hr == 5'd0)       disp_hr = 5'd12;
            else if (src_hr > 5'd12)  disp_hr = src_hr - 5'd12;
        end
        dig[0] = units(tm_sec);
        dig[1] = tens(tm_sec);
        dig[2] = units(src_min);
        dig[3] = tens(src_min);
        dig[4] = units({1'b0, disp_hr});
        dig[5] = tens({1'b0, disp_hr});
        // Alarm edit has no seconds field to show.
        blank  = s.aedit ? 6'b000011 : 6'b000000;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg_digit u_dig (
            .digit (dig[g]),
            .blank (blank[g]),
            .seg   (seg_d[g])
        );
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {NUM_DIGITS{7'b1000000}};
            pm    <= 1'b0;
        end else begin
            seg_q <= seg_d;
            pm    <= (src_hr >= 5'd12);
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
endmodule

// File: tb/tb_watch_core.sv
// Directed bench for watch_core at CLK_HZ=4, ALARM_SECS=3, SYNC_STAGES=2.
module tb_watch_core;
    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] options = '0;
    logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
    logic       pm, alarm;
    logic [41:0] segs;
    int errs = 0;
    int checks = 0;
    int n;

    localparam logic [9:0] RUN = 10'd1, H12 = 10'd2, F_SEC = 10'd4, F_MIN = 10'd8,
                           F_HR = 10'd12, INC = 10'd16, AEDIT = 10'd32, AEN = 10'd64;

    watch_core #(.CLK_HZ(4), .ALARM_SECS(3), .SYNC_STAGES(2)) dut (
        .mclk(mclk), .rst_n(rst_n), .options(options),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5),
        .pm(pm), .alarm(alarm)
    );

    always #5 mclk = ~mclk;
    assign segs = {seg5, seg4, seg3, seg2, seg1, seg0};

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected six digits for displayed hour h (already mode-converted).
    function automatic logic [41:0] disp(input int h, input int m, input int s, input bit bsec);
        logic [6:0] s1, s0;
        s1 = bsec ? 7'h7F : enc(s / 10);
        s0 = bsec ? 7'h7F : enc(s % 10);
        return {enc(h / 10), enc(h % 10), enc(m / 10), enc(m % 10), s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge mclk);
    endtask

    task automatic pulse(input logic [9:0] base, input int k);
        for (int i = 0; i < k; i++) begin
            options = base | INC;
            cyc(4);
            options = base;
            cyc(4);
        end
    endtask

    task automatic show(input string tag, input int h, input int m, input int s, input bit bsec);
        chk(tag, 64'(segs), 64'(disp(h, m, s, bsec)));
    endtask

    task automatic wait_rise(input string tag);
        n = 0;
        while (!alarm && n < 40) begin
            cyc(1);
            n++;
        end
        chk(tag, 64'(alarm), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // reset state
        #12;
        show("rst_segs", 0, 0, 0, 0);
        chk("rst_pm", 64'(pm), 0);
        chk("rst_alarm", 64'(alarm), 0);
        @(negedge mclk);
        rst_n = 1'b1;

        // first tick: 2 sync + 4 prescaler + 1 output
        options = RUN;
        cyc(6);
        chk("pre_tick", 64'(seg0), 64'(enc(0)));
        cyc(1);
        chk("first_tick", 64'(seg0), 64'(enc(1)));
        chk("first_pm", 64'(pm), 0);
        chk("first_alarm", 64'(alarm), 0);
        options = '0;

        // preload 23:59:59, then one tick wraps everything
        pulse(F_HR, 23);
        pulse(F_MIN, 59);
        pulse(F_SEC, 58);
        options = '0;
        cyc(2);
        show("preset", 23, 59, 59, 0);
        chk("preset_pm", 64'(pm), 1);
        options = RUN;
        cyc(7);
        show("wrap24", 0, 0, 0, 0);
        chk("wrap_pm", 64'(pm), 0);
        options = '0;
        cyc(4);
        options = H12;
        cyc(4);
        show("wrap12", 12, 0, 0, 0);
        chk("wrap12_pm", 64'(pm), 0);

        // 12h / 24h hour mapping
        pulse(H12 | F_HR, 13);
        show("h13_12h", 1, 0, 0, 0);
        chk("h13_12h_pm", 64'(pm), 1);
        options = F_HR;
        cyc(4);
        show("h13_24h", 13, 0, 0, 0);
        chk("h13_24h_pm", 64'(pm), 1);
        pulse(H12 | F_HR, 11);
        show("h0_12h", 12, 0, 0, 0);
        chk("h0_12h_pm", 64'(pm), 0);

        // minute wrap without carry, field 00 increment ignored
        pulse(F_HR, 5);
        pulse(F_MIN, 59);
        show("min59", 5, 59, 0, 0);
        pulse(F_MIN, 1);
        show("min_wrap", 5, 0, 0, 0);
        pulse('0, 1);
        show("inc_f00", 5, 0, 0, 0);
        pulse(F_HR, 19);
        show("hr_back0", 0, 0, 0, 0);

        // alarm edit: set 00:01, seconds field ignored
        pulse(AEDIT | F_MIN, 1);
        show("aedit", 0, 1, 0, 1);
        pulse(AEDIT | F_SEC, 1);
        show("aedit_sec_ign", 0, 1, 0, 1);
        pulse(F_SEC, 58);
        show("pre_alarm", 0, 0, 58, 0);

        // alarm rises on tick to 00:01:00, lasts 3 ticks
        options = AEN | RUN;
        wait_rise("alarm_rise");
        chk("rise_lat", 64'(n), 10);
        cyc(1);
        show("at_0100", 0, 1, 0, 0);
        n = 1;
        while (alarm && n < 40) begin
            cyc(1);
            n++;
        end
        chk("alarm_len", 64'(n), 12);
        cyc(1);
        show("off_0103", 0, 1, 3, 0);
        options = AEN;
        cyc(4);
        show("frozen1", 0, 1, 3, 0);

        // again, dropping enable at 00:01:01
        pulse(AEN | F_SEC, 55);
        pulse(AEN | F_MIN, 59);
        show("pre_alarm2", 0, 0, 58, 0);
        options = AEN | RUN;
        wait_rise("alarm_rise2");
        cyc(4);
        chk("alarm_0101", 64'(alarm), 1);
        options = RUN;
        n = 0;
        while (alarm && n < 10) begin
            cyc(1);
            n++;
        end
        chk("drop_lat", 64'(n <= 3), 1);
        chk("drop_alarm", 64'(alarm), 0);
        show("drop_time", 0, 1, 1, 0);
        options = AEN;
        cyc(4);
        show("frozen2", 0, 1, 2, 0);

        // reset mid-alarm and mid-count
        pulse(AEN | F_SEC, 56);
        pulse(AEN | F_MIN, 59);
        options = AEN | RUN;
        wait_rise("alarm_rise3");
        cyc(2);
        rst_n = 1'b0;
        #1;
        show("midrst_segs", 0, 0, 0, 0);
        chk("midrst_pm", 64'(pm), 0);
        chk("midrst_alarm", 64'(alarm), 0);
        options = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        show("post_rst", 0, 0, 0, 0);
        options = AEDIT;
        cyc(4);
        show("post_rst_al", 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
